register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 135 +++++++++++++
 tb/tb_register_file.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: parameterised multi-port register file with two registered
// read ports, one write port, and a clear sweep that zeroes every register
// one index per cycle after reset or a clear request.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  ready,
  input  logic [ADDR_WIDTH-1:0] rs1Num,
  output logic [DATA_WIDTH-1:0] rs1Data,
  input  logic [ADDR_WIDTH-1:0] rs2Num,
  output logic [DATA_WIDTH-1:0] rs2Data,
  input  logic [ADDR_WIDTH-1:0] rdNum,
  input  logic [DATA_WIDTH-1:0] rdData,
  input  logic                  writeEnable
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  // Index of the final register in a sweep; the counter carries one extra bit
  // so reaching it never aliases back to index 0.
  localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rs1Data_q, rs1Data_d;
  logic [DATA_WIDTH-1:0] rs2Data_q, rs2Data_d;
  logic                  wrEn;
  logic [ADDR_WIDTH-1:0] wrIdx;
  logic [DATA_WIDTH-1:0] wrVal;
  logic                  writeCommit;
  wire  [DATA_WIDTH-1:0] regWire [NUM_REGS];

  // Each register gets its own named wire so it can be probed in simulation.
  for (genvar g = 0; g < NUM_REGS; g++) begin : gen_reg_view
    wire [DATA_WIDTH-1:0] value = regs_q[g];
    assign regWire[g] = value;
  end

  // A RUN-state write only lands if no clear accompanies it and it does not
  // target a hardwired zero register.
  assign writeCommit = writeEnable && !clear &&
                       !((ZERO_REG != 0) && (rdNum == '0));

  assign ready   = (state_q == RUN);
  assign rs1Data = rs1Data_q;
  assign rs2Data = rs2Data_q;

  // Read-port value: zero register first, then same-cycle forwarding, then array.
  function automatic logic [DATA_WIDTH-1:0] readPort(
    input logic [ADDR_WIDTH-1:0] num,
    input logic                  commit,
    input logic [ADDR_WIDTH-1:0] wIdx,
    input logic [DATA_WIDTH-1:0] wData,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] result;
    if ((ZERO_REG != 0) && (num == '0)) begin
      result = '0;
    end else if ((BYPASS != 0) && commit && (num == wIdx)) begin
      result = wData;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  // Next-state logic: sweep control, write-port steering and read-data selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wrEn      = 1'b0;
    wrIdx     = rdNum;
    wrVal     = rdData;
    rs1Data_d = '0;
    rs2Data_d = '0;
    unique case (state_q)
      CLEAR: begin
        wrEn  = 1'b1;
        wrIdx = cnt_q[ADDR_WIDTH-1:0];
        wrVal = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
        wrEn      = writeCommit;
        rs1Data_d = readPort(rs1Num, writeCommit, rdNum, rdData, regWire[rs1Num]);
        rs2Data_d = readPort(rs2Num, writeCommit, rdNum, rdData, regWire[rs2Num]);
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // State, sweep counter and registered read data; reset restarts the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      rs1Data_q <= '0;
      rs2Data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rs1Data_q <= rs1Data_d;
      rs2Data_q <= rs2Data_d;
    end
  end

  // Register array: contents survive reset and change only through the write port.
  always_ff @(posedge clk) begin
    if (!reset && wrEn) begin
      regs_q[wrIdx] <= wrVal;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of reset sweep, read/write, zero register,
// bypass on/off, clear sweep and reset during a sweep on a narrow instance.
module tb_register_file;

  logic        clk;
  logic        reset, clear, we;
  logic [4:0]  rs1Num, rs2Num, rdNum;
  logic [31:0] rdData;
  logic        readyA, readyB;
  logic [31:0] rs1A, rs2A, rs1B, rs2B;

  logic        resetC, clearC, weC;
  logic [2:0]  rs1NumC, rs2NumC, rdNumC;
  logic [15:0] rdDataC;
  logic        readyC;
  logic [15:0] rs1C, rs2C;

  int checks;
  int failures;

  register_file dutA (
    .clk(clk), .reset(reset), .clear(clear), .ready(readyA),
    .rs1Num(rs1Num), .rs1Data(rs1A), .rs2Num(rs2Num), .rs2Data(rs2A),
    .rdNum(rdNum), .rdData(rdData), .writeEnable(we)
  );

  register_file #(.BYPASS(0)) dutB (
    .clk(clk), .reset(reset), .clear(clear), .ready(readyB),
    .rs1Num(rs1Num), .rs1Data(rs1B), .rs2Num(rs2Num), .rs2Data(rs2B),
    .rdNum(rdNum), .rdData(rdData), .writeEnable(we)
  );

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dutC (
    .clk(clk), .reset(resetC), .clear(clearC), .ready(readyC),
    .rs1Num(rs1NumC), .rs1Data(rs1C), .rs2Num(rs2NumC), .rs2Data(rs2C),
    .rdNum(rdNumC), .rdData(rdDataC), .writeEnable(weC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fillVal(input int i);
    return 32'h1000_0000 | (i * 32'h0000_0101);
  endfunction

  task automatic test_reset();
    int n;
    @(negedge clk);
    reset = 1'b1; resetC = 1'b1;
    @(negedge clk);
    checks++;
    if (readyA !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_ready got=%b exp=0", readyA);
    end
    checks++;
    if (rs1A !== 32'h0 || rs2A !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_rdata got=%h/%h exp=0", rs1A, rs2A);
    end
    reset = 1'b0; resetC = 1'b0;
    n = 0;
    while (!readyA && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 32) begin
      failures++; $display("[TB] FAIL reset_sweep_len got=%0d exp=32", n);
    end
    for (int i = 0; i < 32; i++) begin
      rs1Num = 5'(i); rs2Num = 5'(31 - i);
      @(negedge clk);
      checks++;
      if (rs1A !== 32'h0 || rs2A !== 32'h0) begin
        failures++; $display("[TB] FAIL reset_zero r%0d got=%h/%h exp=0", i, rs1A, rs2A);
      end
    end
    checks++;
    if (readyA !== 1'b1 || readyB !== 1'b1) begin
      failures++; $display("[TB] FAIL ready_stays got=%b/%b exp=1", readyA, readyB);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we = 1'b1; rdNum = 5'd5; rdData = 32'hDEADBEEF; rs1Num = 5'd1; rs2Num = 5'd2;
    @(negedge clk);
    we = 1'b0; rs1Num = 5'd5; rs2Num = 5'd5;
    @(negedge clk);
    checks++;
    if (rs1A !== 32'hDEADBEEF || rs2A !== 32'hDEADBEEF) begin
      failures++; $display("[TB] FAIL read_r5 got=%h/%h exp=deadbeef", rs1A, rs2A);
    end
    we = 1'b1; rdNum = 5'd31; rdData = 32'h0F0F0F0F;
    @(negedge clk);
    rdNum = 5'd1; rdData = 32'h00000001;
    @(negedge clk);
    we = 1'b0; rs1Num = 5'd31; rs2Num = 5'd1;
    @(negedge clk);
    checks++;
    if (rs1A !== 32'h0F0F0F0F || rs2A !== 32'h00000001) begin
      failures++; $display("[TB] FAIL read_two_ports got=%h/%h exp=0f0f0f0f/00000001", rs1A, rs2A);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    we = 1'b1; rdNum = 5'd10; rdData = 32'h11;
    @(negedge clk);
    rdNum = 5'd11; rdData = 32'h22;
    @(negedge clk);
    rdNum = 5'd12; rdData = 32'h33;
    @(negedge clk);
    we = 1'b0; rs1Num = 5'd10; rs2Num = 5'd12;
    @(negedge clk);
    checks++;
    if (rs1A !== 32'h11 || rs2A !== 32'h33) begin
      failures++; $display("[TB] FAIL b2b_r10_r12 got=%h/%h exp=11/33", rs1A, rs2A);
    end
    rs1Num = 5'd11; rs2Num = 5'd11;
    @(negedge clk);
    checks++;
    if (rs1A !== 32'h22 || rs2A !== 32'h22) begin
      failures++; $display("[TB] FAIL b2b_r11 got=%h/%h exp=22", rs1A, rs2A);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    we = 1'b1; rdNum = 5'd0; rdData = 32'h12345678; rs1Num = 5'd0; rs2Num = 5'd0;
    @(negedge clk);
    we = 1'b0;
    checks++;
    if (rs1A !== 32'h0 || rs1B !== 32'h0) begin
      failures++; $display("[TB] FAIL zero_bypass got=%h/%h exp=0", rs1A, rs1B);
    end
    @(negedge clk);
    checks++;
    if (rs1A !== 32'h0 || rs2B !== 32'h0) begin
      failures++; $display("[TB] FAIL zero_stored got=%h/%h exp=0", rs1A, rs2B);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we = 1'b1; rdNum = 5'd7; rdData = 32'h00000001; rs1Num = 5'd0; rs2Num = 5'd0;
    @(negedge clk);
    rdData = 32'hA5A5A5A5; rs1Num = 5'd7; rs2Num = 5'd7;
    @(negedge clk);
    we = 1'b0;
    checks++;
    if (rs1A !== 32'hA5A5A5A5 || rs2A !== 32'hA5A5A5A5) begin
      failures++; $display("[TB] FAIL bypass_on got=%h/%h exp=a5a5a5a5", rs1A, rs2A);
    end
    checks++;
    if (rs1B !== 32'h00000001 || rs2B !== 32'h00000001) begin
      failures++; $display("[TB] FAIL bypass_off got=%h/%h exp=00000001", rs1B, rs2B);
    end
    @(negedge clk);
    checks++;
    if (rs1A !== 32'hA5A5A5A5 || rs1B !== 32'hA5A5A5A5) begin
      failures++; $display("[TB] FAIL bypass_after got=%h/%h exp=a5a5a5a5", rs1A, rs1B);
    end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; rdNum = 5'(i); rdData = fillVal(i);
    end
    @(negedge clk);
    we = 1'b0; rs1Num = 5'd3; rs2Num = 5'd31;
    @(negedge clk);
    checks++;
    if (rs1A !== fillVal(3) || rs2A !== fillVal(31)) begin
      failures++; $display("[TB] FAIL fill_check got=%h/%h exp=%h/%h", rs1A, rs2A, fillVal(3), fillVal(31));
    end
    clear = 1'b1; we = 1'b1; rdNum = 5'd3; rdData = 32'hFFFFFFFF;
    @(negedge clk);
    clear = 1'b0; we = 1'b1; rdNum = 5'd30; rdData = 32'h00000BAD; rs1Num = 5'd20;
    n = 0;
    while (!readyA && n < 200) begin
      if (n == 2) begin
        checks++;
        if (rs1A !== 32'h0) begin
          failures++; $display("[TB] FAIL clear_read_zero got=%h exp=0", rs1A);
        end
      end
      n++;
      @(negedge clk);
    end
    we = 1'b0;
    checks++;
    if (n !== 32) begin
      failures++; $display("[TB] FAIL clear_sweep_len got=%0d exp=32", n);
    end
    for (int i = 0; i < 32; i++) begin
      rs1Num = 5'(i); rs2Num = 5'(i);
      @(negedge clk);
      checks++;
      if (rs1A !== 32'h0 || rs2B !== 32'h0) begin
        failures++; $display("[TB] FAIL clear_zero r%0d got=%h/%h exp=0", i, rs1A, rs2B);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      weC = 1'b1; rdNumC = 3'(i); rdDataC = 16'hA000 | 16'(i);
    end
    @(negedge clk);
    weC = 1'b0; rs1NumC = 3'd6;
    @(negedge clk);
    checks++;
    if (rs1C !== 16'hA006) begin
      failures++; $display("[TB] FAIL narrow_fill got=%h exp=a006", rs1C);
    end
    clearC = 1'b1;
    @(negedge clk);
    clearC = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (readyC !== 1'b0) begin
      failures++; $display("[TB] FAIL narrow_mid_sweep got=%b exp=0", readyC);
    end
    resetC = 1'b1;
    @(negedge clk);
    resetC = 1'b0;
    n = 0;
    while (!readyC && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 8) begin
      failures++; $display("[TB] FAIL narrow_restart_len got=%0d exp=8", n);
    end
    for (int i = 0; i < 8; i++) begin
      rs1NumC = 3'(i); rs2NumC = 3'(7 - i);
      @(negedge clk);
      checks++;
      if (rs1C !== 16'h0 || rs2C !== 16'h0) begin
        failures++; $display("[TB] FAIL narrow_zero r%0d got=%h/%h exp=0", i, rs1C, rs2C);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; clear = 1'b0; we = 1'b0;
    rs1Num = '0; rs2Num = '0; rdNum = '0; rdData = '0;
    resetC = 1'b0; clearC = 1'b0; weC = 1'b0;
    rs1NumC = '0; rs2NumC = '0; rdNumC = '0; rdDataC = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_zero_reg();
    test_bypass();
    test_clear();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
